// File: rtl/param_array_rf_pkg.sv
// param_array_rf_pkg: shared state encoding, index-width and saturating-add helpers
package param_array_rf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ACTIVE
    } state_e;

    // Widest data word the saturating helper supports.
    localparam int SAT_W = 32;

    // Index width for a given depth; never narrower than one bit.
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Unsigned add of two w-bit values, clamped to 2^w-1.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned w);
        logic [SAT_W:0] s;
        logic [SAT_W:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = ((SAT_W + 1)'(1) << w) - (SAT_W + 1)'(1);
        return (s > m) ? m[SAT_W-1:0] : s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/param_array_rf_sat_acc.sv
// rf_sat_acc: write-value generator, overwrite or saturating accumulate
module rf_sat_acc
    import param_array_rf_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              mode_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] res_o
);

    // Mode 1 adds onto the stored word and clamps at all-ones; mode 0 replaces it.
    always_comb res_o = mode_i ? DATA_W'(sat_add(SAT_W'(old_i), SAT_W'(data_i), DATA_W)) : data_i;

endmodule

// File: rtl/param_array_rf.sv
// param_array_rf: preset-loaded register file with multi-port registered reads
module param_array_rf
    import param_array_rf_pkg::*;
#(
    parameter int                      DATA_W   = 8,
    parameter int                      DEPTH    = 8,
    parameter int                      IDX_W    = clog2(DEPTH),
    parameter int                      NUM_RD   = 2,
    parameter logic [DEPTH*DATA_W-1:0] INIT_VEC = {8'd99, 8'd13, 8'd46, 8'd120, 8'd13, 8'd85, 8'd175, 8'd236},
    parameter int                      BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     reinit,
    output logic                     init_busy,
    output logic                     ready,
    input  logic                     wr_en,
    input  logic                     wr_mode,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     idx_err
);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]         rd_valid_q;
    logic                      idx_err_q, idx_err_d;
    logic                      act;
    logic                      wr_oor;
    logic                      wr_ok;
    logic [DATA_W-1:0]         wr_val;
    logic [NUM_RD-1:0]         rd_act;
    logic [NUM_RD-1:0]         rd_oor;

    assign act       = (state_q == ST_ACTIVE) && en;
    assign wr_oor    = 32'(wr_idx) >= DEPTH;
    assign wr_ok     = act && wr_en && !reinit && !wr_oor;
    assign rd_act    = {NUM_RD{act}} & rd_en;
    assign idx_err_d = act && ((wr_en && wr_oor) || |(rd_en & rd_oor));

    // One adder result feeds both the array write and the same-cycle bypass.
    rf_sat_acc #(.DATA_W(DATA_W)) u_acc (
        .mode_i (wr_mode),
        .old_i  (mem_q[wr_idx]),
        .data_i (wr_data),
        .res_o  (wr_val)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0]  ri;
        logic [DATA_W-1:0] val;
        assign ri        = rd_idx[p*IDX_W +: IDX_W];
        assign rd_oor[p] = 32'(ri) >= DEPTH;
        assign val       = rd_oor[p] ? '0 :
                           ((BYPASS != 0) && wr_ok && (ri == wr_idx)) ? wr_val : mem_q[ri];
        assign rd_data_d[p*DATA_W +: DATA_W] = rd_act[p] ? val : '0;
    end

    // Next state: IDLE waits for en, INIT walks every entry once, ACTIVE can request a reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            ST_INIT: begin
                state_d = (cnt_q == IDX_W'(DEPTH - 1)) ? ST_ACTIVE : ST_INIT;
                cnt_d   = (cnt_q == IDX_W'(DEPTH - 1)) ? '0 : cnt_q + 1'b1;
            end
            ST_ACTIVE: begin
                if (en && reinit) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and read-port registers; array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            idx_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_act;
            idx_err_q  <= idx_err_d;
        end
    end

    // Array storage: preset entries during INIT, user writes in ACTIVE.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT)
            mem_q[cnt_q] <= INIT_VEC[32'(cnt_q)*DATA_W +: DATA_W];
        else if (wr_ok)
            mem_q[wr_idx] <= wr_val;
    end

    assign init_busy = state_q == ST_INIT;
    assign ready     = act;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_param_array_rf.sv
// tb_param_array_rf: three configurations (bypass, no bypass, depth 6) on shared stimulus
module tb_param_array_rf;

    logic       clk = 1'b0;
    logic       reset, en, reinit, wr_en, wr_mode;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic [1:0] rd_en;
    logic [5:0] rd_idx;
    logic [15:0] rdd [3];
    logic [1:0]  rdv [3];
    logic        err [3];
    logic        busy [3];
    logic        rdy [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_array_rf #(.BYPASS(1)) u_bp (
        .clk(clk), .reset(reset), .en(en), .reinit(reinit), .init_busy(busy[0]), .ready(rdy[0]),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rdd[0]), .rd_valid(rdv[0]), .idx_err(err[0]));

    param_array_rf #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .en(en), .reinit(reinit), .init_busy(busy[1]), .ready(rdy[1]),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rdd[1]), .rd_valid(rdv[1]), .idx_err(err[1]));

    param_array_rf #(.DEPTH(6), .INIT_VEC(48'h010203040506)) u_d6 (
        .clk(clk), .reset(reset), .en(en), .reinit(reinit), .init_busy(busy[2]), .ready(rdy[2]),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rdd[2]), .rd_valid(rdv[2]), .idx_err(err[2]));

    // Reference model: phase 0 idle, 1 loading, 2 active.
    int mdep [3] = '{8, 8, 6};
    int mbyp [3] = '{1, 0, 1};
    int pre  [3][8];
    int mem  [3][8];
    int ph   [3];
    int ld   [3];
    int e_rd [3][2];
    int e_v  [3];
    int e_err[3];

    typedef struct {
        bit       we;
        bit       wm;
        int       wi;
        int       wd;
        bit [1:0] re;
        int       r0;
        int       r1;
        int       e0;
        int       e1;
        bit [1:0] ev;
        int       nb0;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic void model_step(int i);
        int  wi, ri, nv, sum;
        bit  wok;
        e_rd[i][0] = 0;
        e_rd[i][1] = 0;
        e_v[i]     = 0;
        e_err[i]   = 0;
        if (reset) begin
            ph[i] = 0;
            ld[i] = 0;
            return;
        end
        if (ph[i] == 0) begin
            if (en) begin
                ph[i] = 1;
                ld[i] = 0;
            end
        end else if (ph[i] == 1) begin
            mem[i][ld[i]] = pre[i][ld[i]];
            ld[i]++;
            if (ld[i] == mdep[i]) ph[i] = 2;
        end else if (en) begin
            wi  = int'(wr_idx);
            wok = wr_en && !reinit && (wi < mdep[i]);
            sum = mem[i][wi] + int'(wr_data);
            nv  = wr_mode ? ((sum > 255) ? 255 : sum) : int'(wr_data);
            if (wr_en && wi >= mdep[i]) e_err[i] = 1;
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    e_v[i] |= (1 << p);
                    ri = int'(rd_idx[p*3 +: 3]);
                    if (ri >= mdep[i]) e_err[i] = 1;
                    else e_rd[i][p] = (mbyp[i] != 0 && wok && ri == wi) ? nv : mem[i][ri];
                end
            end
            if (wok) mem[i][wi] = nv;
            if (reinit) begin
                ph[i] = 1;
                ld[i] = 0;
            end
        end
    endfunction

    task automatic check_model(input int i);
        chk($sformatf("m%0d_rd0", i), int'(rdd[i][7:0]), e_rd[i][0]);
        chk($sformatf("m%0d_rd1", i), int'(rdd[i][15:8]), e_rd[i][1]);
        chk($sformatf("m%0d_valid", i), int'(rdv[i]), e_v[i]);
        chk($sformatf("m%0d_err", i), int'(err[i]), e_err[i]);
        chk($sformatf("m%0d_busy", i), int'(busy[i]), int'(ph[i] == 1));
        chk($sformatf("m%0d_ready", i), int'(rdy[i]), int'(ph[i] == 2 && en));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        for (int i = 0; i < 3; i++) check_model(i);
    endtask

    task automatic idle_in();
        reinit  = 1'b0;
        wr_en   = 1'b0;
        wr_mode = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_idx  = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy[0]) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int iv [8] = '{236, 175, 85, 13, 120, 46, 13, 99};
        int n;
        for (int k = 0; k < 8; k++) begin
            pre[0][k] = iv[k];
            pre[1][k] = iv[k];
            pre[2][k] = (k < 6) ? 6 - k : 0;
            tbl[k] = '{1'b0, 1'b0, 0, 0, 2'b01, k, 0, iv[k], 0, 2'b01, iv[k]};
        end
        tbl[8]  = '{1'b1, 1'b0, 3, 200, 2'b11, 3, 5, 200, 46, 2'b11, 13};
        tbl[9]  = '{1'b1, 1'b1, 0, 100, 2'b10, 0, 0, 0, 255, 2'b10, 0};
        tbl[10] = '{1'b1, 1'b1, 3, 5, 2'b01, 0, 0, 255, 0, 2'b01, 255};
        tbl[11] = '{1'b0, 1'b0, 0, 0, 2'b11, 3, 0, 205, 255, 2'b11, 205};
        tbl[12] = '{1'b0, 1'b0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0};
        tbl[13] = '{1'b0, 1'b0, 0, 0, 2'b11, 6, 6, 13, 13, 2'b11, 13};

        reset = 1'b1;
        en    = 1'b0;
        idle_in();
        tick();
        tick();
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_ready", int'(rdy[0]), 0);
        chk("rst_rd", int'(rdd[0]), 0);
        chk("rst_valid", int'(rdv[0]), 0);
        reset = 1'b0;
        tick();
        en = 1'b1;
        tick();
        count_busy(n);
        chk("init_len", n, 8);
        chk("init_ready", int'(rdy[0]), 1);

        for (int r = 0; r < 14; r++) begin
            wr_en   = tbl[r].we;
            wr_mode = tbl[r].wm;
            wr_idx  = 3'(tbl[r].wi);
            wr_data = 8'(tbl[r].wd);
            rd_en   = tbl[r].re;
            rd_idx  = {3'(tbl[r].r1), 3'(tbl[r].r0)};
            tick();
            chk($sformatf("tbl%0d_rd0", r), int'(rdd[0][7:0]), tbl[r].e0);
            chk($sformatf("tbl%0d_rd1", r), int'(rdd[0][15:8]), tbl[r].e1);
            chk($sformatf("tbl%0d_valid", r), int'(rdv[0]), int'(tbl[r].ev));
            chk($sformatf("tbl%0d_nb_rd0", r), int'(rdd[1][7:0]), tbl[r].nb0);
        end

        en      = 1'b0;
        wr_en   = 1'b1;
        wr_idx  = 3'd2;
        wr_data = 8'd77;
        wr_mode = 1'b0;
        rd_en   = 2'b11;
        rd_idx  = {3'd2, 3'd2};
        tick();
        chk("frz_ready", int'(rdy[0]), 0);
        chk("frz_valid", int'(rdv[0]), 0);
        chk("frz_rd", int'(rdd[0]), 0);
        en = 1'b1;
        idle_in();
        rd_en  = 2'b01;
        rd_idx = {3'd0, 3'd2};
        tick();
        chk("frz_keep", int'(rdd[0][7:0]), 85);
        chk("frz_ready2", int'(rdy[0]), 1);

        idle_in();
        wr_en   = 1'b1;
        wr_idx  = 3'd7;
        wr_data = 8'd33;
        rd_en   = 2'b01;
        rd_idx  = {3'd0, 3'd6};
        tick();
        chk("oor_err", int'(err[2]), 1);
        chk("oor_rd", int'(rdd[2][7:0]), 0);
        chk("oor_valid", int'(rdv[2][0]), 1);
        idle_in();
        rd_en  = 2'b01;
        rd_idx = {3'd0, 3'd5};
        tick();
        chk("oor_err_clr", int'(err[2]), 0);
        chk("oor_keep", int'(rdd[2][7:0]), 1);

        idle_in();
        wr_en   = 1'b1;
        wr_idx  = 3'd2;
        wr_data = 8'd9;
        tick();
        wr_data = 8'd50;
        reinit  = 1'b1;
        rd_en   = 2'b01;
        rd_idx  = {3'd0, 3'd2};
        tick();
        chk("reinit_rd", int'(rdd[0][7:0]), 9);
        idle_in();
        count_busy(n);
        chk("reinit_len", n, 8);
        rd_en  = 2'b11;
        rd_idx = {3'd3, 3'd2};
        tick();
        chk("reinit_idx2", int'(rdd[0][7:0]), 85);
        chk("reinit_idx3", int'(rdd[0][15:8]), 13);

        for (int c = 0; c < 400; c++) begin
            en      = $urandom_range(0, 9) != 0;
            reinit  = $urandom_range(0, 49) == 0;
            wr_en   = 1'($urandom);
            wr_mode = 1'($urandom);
            wr_idx  = 3'($urandom);
            wr_data = 8'($urandom);
            rd_en   = 2'($urandom);
            rd_idx  = 6'($urandom);
            tick();
        end

        en = 1'b1;
        idle_in();
        repeat (12) tick();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_busy", int'(busy[0]), 0);
        chk("mid_ready", int'(rdy[0]), 0);
        chk("mid_rd", int'(rdd[0]), 0);
        chk("mid_err", int'(err[0]), 0);
        reset = 1'b0;
        en    = 1'b0;
        tick();
        en = 1'b1;
        tick();
        count_busy(n);
        chk("restart_len", n, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
